spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl_if.sv | 39 +++
 rtl/spi_cmd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_ctrl_if.sv
// SPI pins plus register-write / command-error strobes of the SPI command controller.
// slave = controller side, master = SPI host and strobe consumer side.
interface spi_cmd_ctrl_if #(
    parameter int P_WORD_W = 16
);
    logic                i_cs;
    logic                i_sclk;
    logic                i_mosi;
    logic                o_miso;
    logic                o_busy;
    logic                o_wr_valid;
    logic [4:0]          o_wr_ch;
    logic [P_WORD_W-1:0] o_wr_data;
    logic                o_cmd_err;

    modport master (
        output i_cs,
        output i_sclk,
        output i_mosi,
        input  o_miso,
        input  o_busy,
        input  o_wr_valid,
        input  o_wr_ch,
        input  o_wr_data,
        input  o_cmd_err
    );

    modport slave (
        input  i_cs,
        input  i_sclk,
        input  i_mosi,
        output o_miso,
        output o_busy,
        output o_wr_valid,
        output o_wr_ch,
        output o_wr_data,
        output o_cmd_err
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI mode-0 command slave: read bursts and writes of a channel register bank; strobes are
// registered one i_clk after the synchronised last SCLK edge; no backpressure, SCLK <= i_clk/8.
module spi_cmd_ctrl #(
    parameter int                  P_WORD_W = 16,
    parameter int                  P_NUM_CH = 8,
    parameter int                  P_BURST  = 5,
    parameter logic [P_WORD_W-1:0] P_INC    = 16'h1111,
    parameter logic [P_WORD_W-1:0] P_INIT   = 16'h89AB,
    parameter logic [7:0]          P_CMD_RD = 8'hF0,
    parameter logic [7:0]          P_CMD_WR = 8'hF1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    spi_cmd_ctrl_if.slave bus
);

    localparam int                CNT_W    = $clog2(P_WORD_W);
    localparam int                CH_W     = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(P_WORD_W - 1);
    localparam logic [5:0]        NUM_CH   = 6'(P_NUM_CH);
    localparam logic [7:0]        BURST_N  = 8'(P_BURST);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_BURST = 2'b01,
        WR_DATA  = 2'b10
    } state_t;

    logic [1:0]          cs_sync;
    logic [1:0]          sclk_sync;
    logic [1:0]          mosi_sync;
    logic                cs_q;
    logic                sclk_q;

    logic [CNT_W-1:0]    bit_cnt;
    logic [P_WORD_W-1:0] rx_sh;
    logic [P_WORD_W-1:0] tx;
    logic [P_WORD_W-1:0] tx_word;
    logic [7:0]          burst_cnt;
    logic [4:0]          wr_ch;
    state_t              state;
    logic [P_WORD_W-1:0] regs [P_NUM_CH];

    logic                busy;
    logic                wr_valid;
    logic [4:0]          wr_ch_out;
    logic [P_WORD_W-1:0] wr_data;
    logic                cmd_err;

    logic                sclk_rise;
    logic                sclk_fall;
    logic                cs_rise;
    logic                cs_act;
    logic                word_done;
    logic [P_WORD_W-1:0] rx_word;
    logic [7:0]          opcode;
    logic [4:0]          rx_ch;
    logic                ch_ok;
    logic [CH_W-1:0]     rx_idx;
    logic [CH_W-1:0]     wr_idx;

    // Synchronisers idle at the bus-idle levels so reset never fakes a frame edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], bus.i_cs};
            sclk_sync <= {sclk_sync[0], bus.i_sclk};
            mosi_sync <= {mosi_sync[0], bus.i_mosi};
            cs_q      <= cs_sync[1];
            sclk_q    <= sclk_sync[1];
        end
    end

    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_q;
        sclk_fall = ~sclk_sync[1] & sclk_q;
        cs_rise   = cs_sync[1] & ~cs_q;
        cs_act    = ~cs_sync[1];
        rx_word   = {rx_sh[P_WORD_W-2:0], mosi_sync[1]};
        word_done = cs_act & sclk_rise & (bit_cnt == LAST_BIT);
        opcode    = rx_word[P_WORD_W-1 -: 8];
        rx_ch     = rx_word[4:0];
        ch_ok     = ({1'b0, rx_ch} < NUM_CH);
        rx_idx    = rx_word[CH_W-1:0];
        wr_idx    = wr_ch[CH_W-1:0];
    end

    // Held at zero whenever cs is high, so every frame starts on a word boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
        end else if (!cs_act) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
        end else if (sclk_rise) begin
            rx_sh   <= rx_word;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            tx        <= '0;
            tx_word   <= '0;
            burst_cnt <= '0;
            wr_ch     <= '0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_ch_out <= '0;
            wr_data   <= '0;
            cmd_err   <= 1'b0;
            for (int k = 0; k < P_NUM_CH; k++) begin
                regs[k] <= P_INIT;
            end
        end else begin
            wr_valid <= 1'b0;
            cmd_err  <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
                busy  <= 1'b0;
                tx    <= '0;
            end else begin
                // The MSB of a freshly loaded word must survive the falling edge after the last bit.
                if (cs_act && sclk_fall && (bit_cnt != '0)) begin
                    tx <= {tx[P_WORD_W-2:0], 1'b0};
                end
                case (state)
                    IDLE: begin
                        if (word_done) begin
                            if (opcode == P_CMD_RD && ch_ok) begin
                                state     <= RD_BURST;
                                busy      <= 1'b1;
                                tx        <= regs[rx_idx];
                                tx_word   <= regs[rx_idx];
                                burst_cnt <= '0;
                            end else if (opcode == P_CMD_WR && ch_ok) begin
                                state <= WR_DATA;
                                busy  <= 1'b1;
                                wr_ch <= rx_ch;
                            end else begin
                                cmd_err <= 1'b1;
                                tx      <= '0;
                            end
                        end
                    end
                    RD_BURST: begin
                        if (word_done) begin
                            burst_cnt <= burst_cnt + 8'd1;
                            if (burst_cnt + 8'd1 == BURST_N) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                tx    <= '0;
                            end else begin
                                tx      <= tx_word + P_INC;
                                tx_word <= tx_word + P_INC;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (word_done) begin
                            regs[wr_idx] <= rx_word;
                            wr_valid     <= 1'b1;
                            wr_ch_out    <= wr_ch;
                            wr_data      <= rx_word;
                            state        <= IDLE;
                            busy         <= 1'b0;
                            tx           <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tx    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_miso     = tx[P_WORD_W-1];
    assign bus.o_busy     = busy;
    assign bus.o_wr_valid = wr_valid;
    assign bus.o_wr_ch    = wr_ch_out;
    assign bus.o_wr_data  = wr_data;
    assign bus.o_cmd_err  = cmd_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed frames plus random command frames against a word-level model.
module tb_spi_cmd_ctrl;
    localparam int          W     = 16;
    localparam int          NCH   = 8;
    localparam int          BURST = 5;
    localparam int          HALF  = 5;
    localparam logic [15:0] INC   = 16'h1111;
    localparam logic [15:0] INIT  = 16'h89AB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_ctrl_if #(.P_WORD_W(W)) bus ();

    spi_cmd_ctrl #(
        .P_WORD_W (W),
        .P_NUM_CH (NCH),
        .P_BURST  (BURST),
        .P_INC    (INC),
        .P_INIT   (INIT),
        .P_CMD_RD (8'hF0),
        .P_CMD_WR (8'hF1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mreg [NCH];
    logic [15:0] fw[$];
    logic [15:0] cap_miso[$];
    logic [15:0] exp_miso[$];
    logic        busy_after[$];
    logic [20:0] exp_wr[$];
    logic [20:0] got_wr[$];
    int          exp_err;
    int          got_err;
    logic        exp_busy = 1'b0;
    bit          chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_wr_valid === 1'b1) got_wr.push_back({bus.o_wr_ch, bus.o_wr_data});
        if (bus.o_cmd_err === 1'b1) got_err++;
        if (chk_en) check("busy", 32'(bus.o_busy), 32'(exp_busy));
    end

    // Word-level model of one frame: which word each MISO slot must carry, busy after each word,
    // and the writes/errors the frame must produce.
    task automatic model_frame();
        int         i;
        int         n;
        int         ch;
        logic [7:0] op;
        i = 0;
        n = fw.size();
        exp_miso.delete();
        busy_after.delete();
        exp_wr.delete();
        exp_err = 0;
        for (int k = 0; k < n; k++) begin
            exp_miso.push_back(16'h0);
            busy_after.push_back(1'b0);
        end
        while (i < n) begin
            op = fw[i][15:8];
            ch = int'(fw[i][4:0]);
            if (op == 8'hF0 && ch < NCH) begin
                busy_after[i] = 1'b1;
                for (int k = 1; k <= BURST && i + k < n; k++) begin
                    exp_miso[i+k]   = mreg[ch] + 16'((k - 1) * int'(INC));
                    busy_after[i+k] = (k < BURST);
                end
                i += BURST + 1;
            end else if (op == 8'hF1 && ch < NCH) begin
                busy_after[i] = 1'b1;
                if (i + 1 < n) begin
                    mreg[ch] = fw[i+1];
                    exp_wr.push_back({5'(ch), fw[i+1]});
                end
                i += 2;
            end else begin
                exp_err++;
                i++;
            end
        end
    endtask

    task automatic send_bits(input logic [15:0] w, input int nb, input logic bnext,
                             output logic [15:0] cap);
        cap = '0;
        for (int b = 15; b > 15 - nb; b--) begin
            bus.i_mosi = w[b];
            chk_en     = 1'b1;
            repeat (HALF) @(negedge clk);
            chk_en     = 1'b0;
            bus.i_sclk = 1'b1;
            cap        = {cap[14:0], bus.o_miso};
            repeat (HALF) @(negedge clk);
            bus.i_sclk = 1'b0;
        end
        if (nb == 16) exp_busy = bnext;
    endtask

    task automatic run_frame(input int tail_bits, input logic [15:0] tail, input bit rst_mid);
        logic [15:0] c;
        model_frame();
        cap_miso.delete();
        got_wr.delete();
        got_err = 0;
        @(negedge clk);
        bus.i_cs = 1'b0;
        for (int j = 0; j < fw.size(); j++) begin
            send_bits(fw[j], 16, busy_after[j], c);
            cap_miso.push_back(c);
        end
        if (tail_bits > 0) send_bits(tail, tail_bits, 1'b0, c);
        if (rst_mid) begin
            chk_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check("rst_miso", 32'(bus.o_miso), 32'h0);
            check("rst_busy", 32'(bus.o_busy), 32'h0);
            check("rst_wr_valid", 32'(bus.o_wr_valid), 32'h0);
            check("rst_cmd_err", 32'(bus.o_cmd_err), 32'h0);
            check("rst_wr_ch", 32'(bus.o_wr_ch), 32'h0);
            check("rst_wr_data", 32'(bus.o_wr_data), 32'h0);
            for (int k = 0; k < NCH; k++) mreg[k] = INIT;
            bus.i_cs   = 1'b1;
            bus.i_sclk = 1'b0;
            bus.i_mosi = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            repeat (HALF) @(negedge clk);
            chk_en   = 1'b0;
            bus.i_cs = 1'b1;
        end
        repeat (6) @(negedge clk);
        exp_busy = 1'b0;
        chk_en   = 1'b1;
        // Stray SCLK activity with cs high must not disturb anything.
        for (int t = 0; t < int'($urandom_range(0, 3)); t++) begin
            bus.i_mosi = 1'($urandom);
            bus.i_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.i_sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        for (int j = 0; j < fw.size(); j++) check("miso_word", 32'(cap_miso[j]), 32'(exp_miso[j]));
        check("wr_count", got_wr.size(), exp_wr.size());
        for (int j = 0; j < exp_wr.size() && j < got_wr.size(); j++)
            check("wr_event", 32'(got_wr[j]), 32'(exp_wr[j]));
        check("err_count", got_err, exp_err);
    endtask

    task automatic check_lits(input int base, input logic [15:0] l0, input logic [15:0] l1,
                              input logic [15:0] l2, input logic [15:0] l3, input logic [15:0] l4);
        logic [15:0] lit [5];
        lit = '{l0, l1, l2, l3, l4};
        for (int k = 0; k < 5; k++) begin
            if (base + k < cap_miso.size()) check("lit_miso", 32'(cap_miso[base+k]), 32'(lit[k]));
            else check("lit_miso_missing", 32'(cap_miso.size()), 32'(base + k + 1));
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] wd;
        int          r;
        int          nw;
        int          tb_bits;

        for (int k = 0; k < NCH; k++) mreg[k] = INIT;
        bus.i_cs   = 1'b1;
        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_miso", 32'(bus.o_miso), 32'h0);
        check("reset_busy", 32'(bus.o_busy), 32'h0);
        check("reset_wr_valid", 32'(bus.o_wr_valid), 32'h0);
        check("reset_cmd_err", 32'(bus.o_cmd_err), 32'h0);
        check("reset_wr_ch", 32'(bus.o_wr_ch), 32'h0);
        check("reset_wr_data", 32'(bus.o_wr_data), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;

        fw = '{16'hF003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check_lits(1, 16'h89AB, 16'h9ABC, 16'hABCD, 16'hBCDE, 16'hCDEF);
        check("burst_busy_end", 32'(bus.o_busy), 32'h0);

        fw = '{16'hF102, 16'h1234};
        run_frame(0, 16'h0, 1'b0);
        check("wr_lit_count", got_wr.size(), 1);
        if (got_wr.size() > 0) check("wr_lit_event", 32'(got_wr[0]), 32'({5'd2, 16'h1234}));
        fw = '{16'hF002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check_lits(1, 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678);

        fw = '{16'hF101, 16'hFFF0, 16'hF001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check_lits(3, 16'hFFF0, 16'h1101, 16'h2212, 16'h3323, 16'h4434);

        fw = '{16'hF009, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check("err_lit_ch9", got_err, 2);
        check("err_lit_miso", 32'(cap_miso[1]), 32'h0);
        fw = '{16'h7700, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check("err_lit_op", got_err, 2);

        fw = '{16'hF101};
        run_frame(7, 16'h5555, 1'b0);
        check("abort_no_write", got_wr.size(), 0);
        fw = '{16'hF001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check_lits(1, 16'hFFF0, 16'h1101, 16'h2212, 16'h3323, 16'h4434);

        for (int f = 0; f < 25; f++) begin
            fw.delete();
            nw = $urandom_range(1, 7);
            for (int k = 0; k < nw; k++) begin
                r = $urandom_range(0, 9);
                if (r < 4)      op = 8'hF0;
                else if (r < 7) op = 8'hF1;
                else            op = 8'($urandom);
                wd = {op, 3'($urandom), 5'($urandom_range(0, 10))};
                if (r == 9) wd = 16'($urandom);
                fw.push_back(wd);
            end
            tb_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            run_frame(tb_bits, 16'($urandom), 1'b0);
        end

        fw = '{16'hF003, 16'h0, 16'h0};
        run_frame(8, 16'h0, 1'b1);
        fw = '{16'hF003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check_lits(1, 16'h89AB, 16'h9ABC, 16'hABCD, 16'hBCDE, 16'hCDEF);
        fw = '{16'hF001, 16'h0};
        run_frame(0, 16'h0, 1'b0);
        check("post_rst_ch1", 32'(cap_miso[1]), 32'(INIT));

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
